// File: rtl/hog_pkg.sv
// rtl/hog_pkg.sv - shared constants and width rules for the HOG cell histogram
//
// Purpose: bin-count constants, the default cell size, the drain FSM state
// type and the accumulator width rule shared by the histogram files.
// Ports: none (package).
package hog_pkg;

    localparam int NUM_BINS            = 18;
    localparam int BIN_IDX_W           = 5;
    localparam int CELL_PIXELS_DEFAULT = 64;

    // Sized bin constants so index comparisons stay width-matched.
    localparam logic [BIN_IDX_W-1:0] BIN_LIMIT = BIN_IDX_W'(NUM_BINS);
    localparam logic [BIN_IDX_W-1:0] BIN_LAST  = BIN_IDX_W'(NUM_BINS - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_t;

    // An accumulator that never saturates needs room for CELL_PIXELS full-scale
    // magnitudes; narrower accumulators are legal and saturate.
    function automatic int acc_width_for(input int mag_w, input int cell_px);
        return mag_w + $clog2(cell_px);
    endfunction

endpackage

// File: rtl/hog_cell_histogram_if.sv
// rtl/hog_cell_histogram_if.sv - pixel input and histogram output stream bundle
//
// Purpose: groups the per-pixel bin/magnitude input and the bin-by-bin
// histogram output handshake.
// master: the histogram producer (consumes pixels, drives hist_* beats).
// slave : the surrounding logic (drives pixels and hist_ready).
interface hog_cell_histogram_if import hog_pkg::*; #(
    parameter int MAG_WIDTH = 16,
    parameter int ACC_WIDTH = 22
);
    logic [BIN_IDX_W-1:0] bin_num;
    logic [MAG_WIDTH-1:0] magnitude;
    logic                 bin_num_valid;
    logic [ACC_WIDTH-1:0] hist_data;
    logic [BIN_IDX_W-1:0] hist_idx;
    logic                 hist_valid;
    logic                 hist_last;
    logic                 hist_ready;

    modport master (
        input  bin_num, magnitude, bin_num_valid, hist_ready,
        output hist_data, hist_idx, hist_valid, hist_last
    );

    modport slave (
        output bin_num, magnitude, bin_num_valid, hist_ready,
        input  hist_data, hist_idx, hist_valid, hist_last
    );
endinterface

// File: rtl/hog_hist_bank.sv
// rtl/hog_hist_bank.sv - one NUM_BINS-entry saturating accumulator bank
//
// Purpose: holds one cell histogram.
// Ports: clk, rst (async, active-high)
//        i_add_en/i_add_idx/i_add_mag : saturating read-modify-write add
//        i_rd_idx/o_rd_data          : combinational read port
//        i_clr_en                    : zero the entry at i_rd_idx
module hog_hist_bank import hog_pkg::*; #(
    parameter int MAG_WIDTH = 16,
    parameter int ACC_WIDTH = 22
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_add_en,
    input  logic [BIN_IDX_W-1:0] i_add_idx,
    input  logic [MAG_WIDTH-1:0] i_add_mag,
    input  logic [BIN_IDX_W-1:0] i_rd_idx,
    output logic [ACC_WIDTH-1:0] o_rd_data,
    input  logic                 i_clr_en
);

    logic [ACC_WIDTH-1:0] r_acc [NUM_BINS];
    logic [ACC_WIDTH-1:0] w_add_cur;
    logic [ACC_WIDTH:0]   w_sum;
    logic [ACC_WIDTH-1:0] w_sat;

    always_comb begin
        w_add_cur = (i_add_idx < BIN_LIMIT) ? r_acc[i_add_idx] : '0;
        w_sum     = {1'b0, w_add_cur} + {{(ACC_WIDTH + 1 - MAG_WIDTH){1'b0}}, i_add_mag};
        // The carry out of the extended sum means the true total no longer fits.
        w_sat     = w_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
        o_rd_data = (i_rd_idx < BIN_LIMIT) ? r_acc[i_rd_idx] : '0;
    end

    // Adds target the write bank and clears target the drain bank, so both never
    // hit one bank together; add is given priority anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BINS; i++) begin
                if (i_add_en && (i_add_idx == BIN_IDX_W'(i))) begin
                    r_acc[i] <= w_sat;
                end else if (i_clr_en && (i_rd_idx == BIN_IDX_W'(i))) begin
                    r_acc[i] <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/hog_cell_histogram.sv
// rtl/hog_cell_histogram.sv - ping-pong per-cell orientation histogram with stream drain
//
// Purpose: accumulates pixel magnitudes into an 18-bin histogram per cell of
// CELL_PIXELS pixels and drains finished histograms one bin per beat.
// Ports: aclk, areset (async, active-high)
//        hist_if (master): bin_num/magnitude/bin_num_valid in,
//                          hist_data/hist_idx/hist_valid/hist_last out, hist_ready in
//        err_clr   : clears the sticky error flags
//        cell_done : one-cycle pulse after a cell's last pixel is accepted
//        bin_err   : sticky, out-of-range bin seen
//        overrun   : sticky, pixel dropped because both banks were busy
module hog_cell_histogram import hog_pkg::*; #(
    parameter int MAG_WIDTH   = 16,
    parameter int ACC_WIDTH   = 22,
    parameter int CELL_PIXELS = CELL_PIXELS_DEFAULT
) (
    input  logic                 aclk,
    input  logic                 areset,
    hog_cell_histogram_if.master hist_if,
    input  logic                 err_clr,
    output logic                 cell_done,
    output logic                 bin_err,
    output logic                 overrun
);

    localparam int              PIX_W    = $clog2(CELL_PIXELS);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(CELL_PIXELS - 1);

    drain_state_t          r_state;
    drain_state_t          w_state_nxt;
    logic [BIN_IDX_W-1:0]  r_idx;
    logic [BIN_IDX_W-1:0]  w_idx_nxt;
    logic [PIX_W-1:0]      r_pix_cnt;
    logic                  r_wr_bank;
    logic                  r_rd_bank;
    logic                  r_pending;
    logic                  r_cell_done;
    logic                  r_bin_err;
    logic                  r_overrun;

    logic                  w_bin_ok;
    logic                  w_accept;
    logic                  w_last_pix;
    logic                  w_hs;
    logic                  w_drain_done;
    logic                  w_swap;
    logic                  w_hist_valid;
    logic                  w_hist_last;
    logic [ACC_WIDTH-1:0]  w_hist_data;
    logic [ACC_WIDTH-1:0]  w_rd_data [2];

    assign w_bin_ok     = (hist_if.bin_num < BIN_LIMIT);
    assign w_accept     = hist_if.bin_num_valid && !r_pending;
    assign w_last_pix   = w_accept && (r_pix_cnt == PIX_LAST);
    assign w_hs         = (r_state == ST_DRAIN) && hist_if.hist_ready;
    assign w_drain_done = w_hs && (r_idx == BIN_LAST);
    // A finished cell (just now, or parked in pending) moves to the drain side as
    // soon as the drain side is free, including the edge its last beat leaves.
    assign w_swap       = (w_last_pix || r_pending) && ((r_state == ST_IDLE) || w_drain_done);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        hog_hist_bank #(
            .MAG_WIDTH (MAG_WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_bank (
            .clk       (aclk),
            .rst       (areset),
            .i_add_en  (w_accept && w_bin_ok && (r_wr_bank == 1'(b))),
            .i_add_idx (hist_if.bin_num),
            .i_add_mag (hist_if.magnitude),
            .i_rd_idx  (r_idx),
            .o_rd_data (w_rd_data[b]),
            .i_clr_en  (w_hs && (r_rd_bank == 1'(b)))
        );
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_hist_valid = 1'b0;
        w_hist_last  = 1'b0;
        w_hist_data  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_swap) begin
                    w_state_nxt = ST_DRAIN;
                    w_idx_nxt   = '0;
                end
            end
            ST_DRAIN: begin
                w_hist_valid = 1'b1;
                w_hist_data  = w_rd_data[r_rd_bank];
                w_hist_last  = (r_idx == BIN_LAST);
                if (w_hs) begin
                    if (r_idx == BIN_LAST) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = w_swap ? ST_DRAIN : ST_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_pix_cnt   <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_pending   <= 1'b0;
            r_cell_done <= 1'b0;
            r_bin_err   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pix_cnt <= w_last_pix ? '0 : r_pix_cnt + 1'b1;
            end
            if (w_swap) begin
                r_rd_bank <= r_wr_bank;
                r_wr_bank <= ~r_wr_bank;
                r_pending <= 1'b0;
            end else if (w_last_pix) begin
                r_pending <= 1'b1;
            end
            r_cell_done <= w_last_pix;
            if (w_accept && !w_bin_ok) begin
                r_bin_err <= 1'b1;
            end else if (err_clr) begin
                r_bin_err <= 1'b0;
            end
            if (hist_if.bin_num_valid && r_pending) begin
                r_overrun <= 1'b1;
            end else if (err_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign hist_if.hist_valid = w_hist_valid;
    assign hist_if.hist_last  = w_hist_last;
    assign hist_if.hist_data  = w_hist_data;
    assign hist_if.hist_idx   = r_idx;
    assign cell_done          = r_cell_done;
    assign bin_err            = r_bin_err;
    assign overrun            = r_overrun;

endmodule
